// File: rtl/mlp_train_scheduler_pkg.sv
// Shared types and fixed-point helpers for the MLP training scheduler.
// sfp is signed Q8.8; helpers give absolute value and saturating addition.
package mlp_train_scheduler_pkg;

    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp SFP_MAX = {1'b0, {(SFP_W-1){1'b1}}};
    localparam sfp SFP_MIN = {1'b1, {(SFP_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SETTLE,
        UPDATE,
        EPOCH_END,
        DONE
    } train_state_t;

    // The most-negative value has no positive twin, so it clamps to SFP_MAX.
    function automatic sfp sfp_abs(input sfp a);
        if (a == SFP_MIN) begin
            return SFP_MAX;
        end
        return a[SFP_W-1] ? -a : a;
    endfunction

    function automatic sfp sfp_add_sat(input sfp a, input sfp b);
        logic signed [SFP_W:0] s;
        s = {a[SFP_W-1], a} + {b[SFP_W-1], b};
        if (s[SFP_W] != s[SFP_W-1]) begin
            return s[SFP_W] ? SFP_MIN : SFP_MAX;
        end
        return s[SFP_W-1:0];
    endfunction

endpackage

// File: rtl/mlp_train_scheduler_loss_accum.sv
// Per-epoch loss accumulator: saturating sum of |value| while enabled.
// clear wins over enable and empties the running sum.
module mlp_loss_accum
    import mlp_train_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  sfp   value,
    output sfp   sum
);

    // NOTE: clocked state is written with <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sfp_add_sat(sum, sfp_abs(value));
        end
    end

endmodule

// File: rtl/mlp_train_scheduler.sv
// Training sequencer for one MLP layer: init pulse, per-sample settle/update, per-epoch loss.
// Optional learning-rate halving per epoch is enabled by defining MLP_TRAIN_LR_DECAY_EN.
module mlp_train_scheduler
    import mlp_train_scheduler_pkg::*;
#(
    parameter int NUM_SAMPLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    parameter int EPOCH_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [EPOCH_W-1:0] epochs,
    input  sfp                 learning_rate_in,
    input  sfp                 output_error,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               layer_init,
    output logic               training,
    output sfp                 learning_rate,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch_count,
    output sfp                 epoch_loss
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    train_state_t       state;
    train_state_t       state_next;
    logic [CNT_W-1:0]   settle_cnt;
    logic [EPOCH_W-1:0] epoch_target;
    logic [EPOCH_W-1:0] epoch_next;
    logic               last_sample;
    logic               run_finish;
    logic               load_run;
    logic               next_sample;
    logic               end_epoch;
    logic               acc_en;
    logic               acc_clear;
    sfp                 acc_sum;

    assign epoch_next  = epoch_count + EPOCH_W'(1);
    assign last_sample = (sample_idx == IDX_W'(NUM_SAMPLES - 1));
    assign run_finish  = (epoch_next == epoch_target);
    assign busy        = (state != IDLE);
    assign acc_clear   = load_run | end_epoch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_next  = state;
        layer_init  = 1'b0;
        training    = 1'b0;
        done        = 1'b0;
        load_run    = 1'b0;
        next_sample = 1'b0;
        end_epoch   = 1'b0;
        acc_en      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load_run   = 1'b1;
                    state_next = (epochs == '0) ? DONE : INIT;
                end
            end
            INIT: begin
                layer_init = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                training = 1'b1;
                acc_en   = 1'b1;
                if (last_sample) begin
                    state_next = EPOCH_END;
                end else begin
                    next_sample = 1'b1;
                    state_next  = SETTLE;
                end
            end
            EPOCH_END: begin
                end_epoch  = 1'b1;
                state_next = run_finish ? DONE : SETTLE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort freezes all bookkeeping; the strobes drop with the state change.
        if (abort && state != IDLE) begin
            state_next  = IDLE;
            acc_en      = 1'b0;
            next_sample = 1'b0;
            end_epoch   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_idx    <= '0;
            learning_rate <= '0;
            epoch_count   <= '0;
            epoch_loss    <= '0;
            epoch_target  <= '0;
            settle_cnt    <= '0;
        end else begin
            settle_cnt <= (state == SETTLE && state_next == SETTLE) ? settle_cnt + CNT_W'(1) : '0;
            if (load_run) begin
                epoch_target  <= epochs;
                learning_rate <= learning_rate_in;
                epoch_count   <= '0;
                sample_idx    <= '0;
            end
            if (next_sample) begin
                sample_idx <= sample_idx + IDX_W'(1);
            end
            if (end_epoch) begin
                epoch_loss  <= acc_sum;
                epoch_count <= epoch_next;
                sample_idx  <= '0;
`ifdef MLP_TRAIN_LR_DECAY_EN
                // Halve between epochs but never below one LSB.
                if (!run_finish && learning_rate != sfp'(1)) begin
                    learning_rate <= learning_rate >>> 1;
                end
`endif
            end
        end
    end

    mlp_loss_accum u_loss_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .enable (acc_en),
        .value  (output_error),
        .sum    (acc_sum)
    );

endmodule
